// File: rtl/urv_dm_arbiter.sv
// Two-master (CPU / debug) round-robin arbiter and sequencer for the uRV data-memory port.
// Optional watchdog abort of hung memory cycles is enabled by defining URV_DM_ARB_TIMEOUT_EN.
module urv_dm_arbiter #(
  parameter int unsigned g_timeout_cycles = 1023
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_s_i,
  input  logic [3:0]  cpu_data_select_i,
  input  logic        cpu_load_i,
  input  logic        cpu_store_i,
  output logic [31:0] cpu_data_l_o,
  output logic        cpu_ready_o,

  input  logic [31:0] dbg_addr_i,
  input  logic [31:0] dbg_data_s_i,
  input  logic [3:0]  dbg_data_select_i,
  input  logic        dbg_load_i,
  input  logic        dbg_store_i,
  output logic [31:0] dbg_data_l_o,
  output logic        dbg_ready_o,

  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_s_o,
  output logic [3:0]  mem_data_select_o,
  output logic        mem_load_o,
  output logic        mem_store_o,
  input  logic [31:0] mem_data_l_i,
  input  logic        mem_ready_i,

  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  localparam logic [15:0] TLIM = 16'(g_timeout_cycles);

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_dbg_q, last_dbg_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic        store_q, store_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] dbg_rdata_q, dbg_rdata_d;

  logic        cpu_req, dbg_req, pick_dbg;
  logic        wd_expired;
  logic [31:0] result;

  assign cpu_req  = cpu_load_i | cpu_store_i;
  assign dbg_req  = dbg_load_i | dbg_store_i;
  // On a tie the master that did not own the previous transaction wins.
  assign pick_dbg = dbg_req & (~cpu_req | ~last_dbg_q);
  assign result   = mem_ready_i ? mem_data_l_i : 32'hDEADBEEF;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_dbg_q  <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      store_q     <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_dbg_q  <= last_dbg_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      store_q     <= store_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_dbg_d  = last_dbg_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    store_d     = store_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req || dbg_req) begin
          if (pick_dbg) begin
            addr_d  = dbg_addr_i;
            wdata_d = dbg_data_s_i;
            sel_d   = dbg_data_select_i;
            store_d = dbg_store_i;
            grant_d = 2'b10;
          end else begin
            addr_d  = cpu_addr_i;
            wdata_d = cpu_data_s_i;
            sel_d   = cpu_data_select_i;
            store_d = cpu_store_i;
            grant_d = 2'b01;
          end
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ready_i || wd_expired) begin
          if (grant_q[1]) dbg_rdata_d = result;
          else            cpu_rdata_d = result;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        last_dbg_d = grant_q[1];
        grant_d    = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef URV_DM_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;

  // Counter is held at zero outside BUSY, so it starts from zero on every BUSY entry.
  assign wd_expired = (state_q == ST_BUSY) && (wd_cnt_q == TLIM);

  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    timeout_d = 1'b0;
    if (state_q != ST_BUSY) begin
      wd_cnt_d = '0;
    end else if (!mem_ready_i) begin
      wd_cnt_d  = wd_cnt_q + 16'd1;
      timeout_d = wd_expired;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TLIM;
  assign wd_expired         = 1'b0;
  assign timeout_o          = 1'b0;
`endif

  assign mem_addr_o        = addr_q;
  assign mem_data_s_o      = wdata_q;
  assign mem_data_select_o = sel_q;
  assign mem_load_o        = (state_q == ST_BUSY) & ~store_q;
  assign mem_store_o       = (state_q == ST_BUSY) &  store_q;

  assign grant_o      = grant_q;
  assign cpu_data_l_o = cpu_rdata_q;
  assign dbg_data_l_o = dbg_rdata_q;
  assign cpu_ready_o  = (state_q == ST_DONE) & grant_q[0];
  assign dbg_ready_o  = (state_q == ST_DONE) & grant_q[1];

endmodule

// File: tb/tb_urv_dm_arbiter.sv
// Directed self-checking bench for urv_dm_arbiter; the watchdog case follows URV_DM_ARB_TIMEOUT_EN.
module tb_urv_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr, cpu_data_s, dbg_addr, dbg_data_s, mem_data_l;
  logic [3:0]  cpu_sel, dbg_sel;
  logic        cpu_load, cpu_store, dbg_load, dbg_store, mem_ready;
  logic [31:0] cpu_data_l, dbg_data_l, mem_addr, mem_data_s;
  logic [3:0]  mem_sel;
  logic        cpu_ready, dbg_ready, mem_load, mem_store, timeout;
  logic [1:0]  grant;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned n_mem, n_rdy;

  always #5 clk = ~clk;

  urv_dm_arbiter #(.g_timeout_cycles(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_addr_i(cpu_addr), .cpu_data_s_i(cpu_data_s), .cpu_data_select_i(cpu_sel),
    .cpu_load_i(cpu_load), .cpu_store_i(cpu_store), .cpu_data_l_o(cpu_data_l), .cpu_ready_o(cpu_ready),
    .dbg_addr_i(dbg_addr), .dbg_data_s_i(dbg_data_s), .dbg_data_select_i(dbg_sel),
    .dbg_load_i(dbg_load), .dbg_store_i(dbg_store), .dbg_data_l_o(dbg_data_l), .dbg_ready_o(dbg_ready),
    .mem_addr_o(mem_addr), .mem_data_s_o(mem_data_s), .mem_data_select_o(mem_sel),
    .mem_load_o(mem_load), .mem_store_o(mem_store), .mem_data_l_i(mem_data_l), .mem_ready_i(mem_ready),
    .grant_o(grant), .timeout_o(timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    cpu_addr = '0; cpu_data_s = '0; cpu_sel = '0; cpu_load = 0; cpu_store = 0;
    dbg_addr = '0; dbg_data_s = '0; dbg_sel = '0; dbg_load = 0; dbg_store = 0;
    mem_data_l = '0; mem_ready = 0;
    tick(); tick();

    // Reset values
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_mem_req", 32'({mem_load, mem_store}), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_data", mem_data_s, 32'h0);
    check("rst_mem_sel", 32'(mem_sel), 32'h0);
    check("rst_ready", 32'({cpu_ready, dbg_ready}), 32'h0);
    check("rst_cpu_dl", cpu_data_l, 32'h0);
    check("rst_dbg_dl", dbg_data_l, 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    rst = 1'b0;

    // CPU load, memory ready in first BUSY cycle
    cpu_addr = 32'h100; cpu_sel = 4'hF; cpu_load = 1;
    check("ld_c0_memload", 32'(mem_load), 32'h0);
    tick();
    check("ld_c1_memload", 32'(mem_load), 32'h1);
    check("ld_c1_addr", mem_addr, 32'h100);
    check("ld_c1_grant", 32'(grant), 32'h1);
    check("ld_c1_ready", 32'(cpu_ready), 32'h0);
    mem_ready = 1; mem_data_l = 32'h12345678;
    tick();
    check("ld_c2_memload", 32'(mem_load), 32'h0);
    check("ld_c2_cpu_ready", 32'(cpu_ready), 32'h1);
    check("ld_c2_dbg_ready", 32'(dbg_ready), 32'h0);
    check("ld_c2_data", cpu_data_l, 32'h12345678);
    cpu_load = 0; mem_ready = 0;
    tick();
    check("ld_c3_cpu_ready", 32'(cpu_ready), 32'h0);
    check("ld_c3_grant", 32'(grant), 32'h0);

    // Simultaneous requests after reset: CPU, debug, CPU
    rst = 1; tick(); rst = 0;
    cpu_load = 1; dbg_load = 1; dbg_addr = 32'h200; mem_ready = 1; mem_data_l = 32'hCAFE0001;
    tick();
    check("tie_c1_grant", 32'(grant), 32'h1);
    check("tie_c1_addr", mem_addr, 32'h100);
    tick();
    check("tie_c2_ready", 32'({dbg_ready, cpu_ready}), 32'h1);
    check("tie_c2_cpu_dl", cpu_data_l, 32'hCAFE0001);
    tick();
    check("tie_c3_memreq", 32'({mem_load, mem_store}), 32'h0);
    tick();
    check("tie_c4_grant", 32'(grant), 32'h2);
    check("tie_c4_addr", mem_addr, 32'h200);
    mem_data_l = 32'hCAFE0002;
    tick();
    check("tie_c5_ready", 32'({dbg_ready, cpu_ready}), 32'h2);
    check("tie_c5_dbg_dl", dbg_data_l, 32'hCAFE0002);
    check("tie_c5_cpu_hold", cpu_data_l, 32'hCAFE0001);
    tick(); tick();
    check("tie_c7_grant", 32'(grant), 32'h1);
    cpu_load = 0; dbg_load = 0; mem_data_l = 32'hCAFE0003;
    tick();
    check("tie_c8_ready", 32'({dbg_ready, cpu_ready}), 32'h1);
    mem_ready = 0;
    tick();

    // Debug store with memory ready delayed 5 cycles
    dbg_addr = 32'h2000; dbg_data_s = 32'hA5A5A5A5; dbg_sel = 4'b1111; dbg_store = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("st_busy_store", 32'({mem_store, mem_load}), 32'h2);
      check("st_busy_addr", mem_addr, 32'h2000);
      check("st_busy_data", mem_data_s, 32'hA5A5A5A5);
      check("st_busy_sel", 32'(mem_sel), 32'hF);
      check("st_busy_ready", 32'(dbg_ready), 32'h0);
      tick();
    end
    check("st_b6_store", 32'(mem_store), 32'h1);
    check("st_b6_addr", mem_addr, 32'h2000);
    mem_ready = 1; mem_data_l = 32'h0BADF00D;
    tick();
    check("st_done_ready", 32'(dbg_ready), 32'h1);
    check("st_done_store", 32'(mem_store), 32'h0);
    check("st_cpu_dl_hold", cpu_data_l, 32'hCAFE0003);
    dbg_store = 0; mem_ready = 0;
    tick();
    check("st_after_ready", 32'(dbg_ready), 32'h0);

    // Reset in third BUSY cycle abandons the transaction
    cpu_addr = 32'h300; cpu_data_s = 32'h33333333; cpu_store = 1;
    tick(); tick(); tick();
    check("rs_b3_store", 32'(mem_store), 32'h1);
    rst = 1;
    tick();
    check("rs_memstore", 32'(mem_store), 32'h0);
    check("rs_grant", 32'(grant), 32'h0);
    check("rs_mem_addr", mem_addr, 32'h0);
    check("rs_cpu_dl", cpu_data_l, 32'h0);
    rst = 0; cpu_store = 0;
    tick();
    check("rs_no_ready", 32'({dbg_ready, cpu_ready}), 32'h0);
    dbg_addr = 32'h40; dbg_load = 1; mem_ready = 1; mem_data_l = 32'h11110000;
    tick();
    check("rs_new_grant", 32'(grant), 32'h2);
    check("rs_new_load", 32'(mem_load), 32'h1);
    tick();
    check("rs_new_ready", 32'(dbg_ready), 32'h1);
    check("rs_new_dl", dbg_data_l, 32'h11110000);
    dbg_load = 0; mem_ready = 0;
    tick();

    // Hung memory cycle
    cpu_addr = 32'h400; cpu_load = 1; mem_data_l = 32'h55555555;
    tick();
`ifdef URV_DM_ARB_TIMEOUT_EN
    for (int i = 0; i < 9; i++) begin
      check("to_busy_load", 32'(mem_load), 32'h1);
      check("to_busy_timeout", 32'(timeout), 32'h0);
      tick();
    end
    check("to_timeout", 32'(timeout), 32'h1);
    check("to_cpu_ready", 32'(cpu_ready), 32'h1);
    check("to_cpu_dl", cpu_data_l, 32'hDEADBEEF);
    check("to_memload", 32'(mem_load), 32'h0);
    cpu_load = 0;
    tick();
    check("to_strobe_end", 32'(timeout), 32'h0);
`else
    for (int i = 0; i < 120; i++) begin
      check("hang_busy_load", 32'({mem_load, cpu_ready, timeout}), 32'h4);
      tick();
    end
    cpu_load = 0; rst = 1;
    tick();
    rst = 0;
    check("hang_rst_load", 32'(mem_load), 32'h0);
`endif

    // Store then load from the CPU: exactly two memory transactions
    cpu_addr = 32'h500; cpu_data_s = 32'h77777777; cpu_store = 1; mem_ready = 1;
    mem_data_l = 32'h99990000;
    n_mem = 0; n_rdy = 0;
    for (int i = 0; i < 9; i++) begin
      if (mem_load || mem_store) n_mem++;
      if (i == 1) check("sl_first_store", 32'({mem_store, mem_load}), 32'h2);
      if (i == 4) check("sl_second_load", 32'({mem_store, mem_load}), 32'h1);
      if (cpu_ready) begin
        n_rdy++;
        if (n_rdy == 1) begin
          cpu_store = 0; cpu_load = 1;
        end else begin
          cpu_load = 0;
        end
      end
      tick();
    end
    check("sl_mem_txns", n_mem, 32'd2);
    check("sl_ready_count", n_rdy, 32'd2);
    check("sl_load_dl", cpu_data_l, 32'h99990000);
    mem_ready = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/urv_dm_arbiter.md
# urv_dm_arbiter

Two-master arbiter and sequencer for the uRV data-memory port: it shares one memory port between the execute stage's load/store port (CPU master) and a debug/DMA master. It sits between the execute/writeback stages and the data memory. Each grant is captured into registers, one transaction is run to completion on the memory port, and the result is returned to the granted master. Arbitration is round-robin, and an optional watchdog aborts hung memory cycles.

## Interface
Parameters:
- g_timeout_cycles, default 1023: watchdog limit in cycles, range 1..65535; used only with URV_DM_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock; all logic is on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cpu_addr_i  in  32  CPU byte address.
- cpu_data_s_i  in  32  CPU store data, already lane-replicated.
- cpu_data_select_i  in  4  CPU byte-lane enables.
- cpu_load_i  in  1  CPU load request level.
- cpu_store_i  in  1  CPU store request level.
- cpu_data_l_o  out  32  load data returned to the CPU.
- cpu_ready_o  out  1  one-cycle completion strobe to the CPU.
- dbg_addr_i, dbg_data_s_i, dbg_data_select_i, dbg_load_i, dbg_store_i, dbg_data_l_o, dbg_ready_o: same meaning as the cpu_* ports, for the secondary master.
- mem_addr_o  out  32  memory address.
- mem_data_s_o  out  32  memory store data.
- mem_data_select_o  out  4  memory byte-lane enables.
- mem_load_o  out  1  memory load request.
- mem_store_o  out  1  memory store request.
- mem_data_l_i  in  32  memory load data, valid when mem_ready_i=1.
- mem_ready_i  in  1  memory completion for the current request.
- grant_o  out  2  current owner: 01 = CPU, 10 = debug, 00 = none.
- timeout_o  out  1  one-cycle strobe when a transaction is aborted.

## Operation
Request protocol:
- A master raises load or store with address, data and select, and holds all of them stable until its ready_o strobe.
- If load and store are both asserted, the request is treated as a store.

State machine states are IDLE, BUSY and DONE.
- IDLE:
  - If any request is present, capture the winner's addr, data, select and op into registers, set grant_o, and go to BUSY.
  - With no request, stay in IDLE.
- BUSY:
  - mem_load_o or mem_store_o is driven from the captured op.
  - mem_addr_o, mem_data_s_o and mem_data_select_o are driven from registers.
  - When mem_ready_i=1: latch mem_data_l_i into the owner's data_l_o register and go to DONE.
- DONE:
  - The owner's ready_o is 1 for exactly this cycle. The memory request is deasserted.
  - No capture happens in DONE, so a still-held request is not re-issued.
  - Update last_grant to the owner and go to IDLE.

Arbitration:
- A single request is granted immediately.
- With simultaneous requests in IDLE, grant the master that is not last_grant.
- last_grant resets to debug, so the CPU wins the first tie.
- A master is never granted twice in a row while the other is waiting.

Other rules:
- Requests that arrive during BUSY or DONE wait in IDLE; the arbiter has no queue.
- The data_l_o register of the non-owner holds its previous value.
- For stores, the owner's data_l_o is loaded with mem_data_l_i anyway. Contents are don't-care.

## Timing
- Reset values:
  - state IDLE; grant_o=00; last_grant=debug.
  - mem_load_o=0, mem_store_o=0, mem_addr_o=0, mem_data_s_o=0, mem_data_select_o=0.
  - cpu_ready_o=0, dbg_ready_o=0, cpu_data_l_o=0, dbg_data_l_o=0.
  - timeout_o=0; watchdog counter=0.
- Latency, with the request seen in IDLE at cycle 0:
  - mem request asserted in cycle 1.
  - If mem_ready_i=1 in cycle 1+k, ready_o=1 in cycle 2+k.
  - Minimum request-to-ready latency is 2 cycles.
  - Back-to-back transactions issue at most one per 3 cycles.
- The mem request stays asserted and stable from BUSY entry until the cycle mem_ready_i=1 inclusive. It is 0 in DONE.
- mem_ready_i is ignored outside BUSY.
- Reset asserted mid-transaction: at the next edge everything returns to reset values. The memory request drops and the outstanding transaction is abandoned with no ready strobe.
- A master that drops its request before ready_o is a protocol violation. The captured transaction still completes and ready_o still pulses.

## Configuration
Macro: URV_DM_ARB_TIMEOUT_EN.

When defined:
- A 16-bit counter clears on BUSY entry and increments each BUSY cycle with mem_ready_i=0.
- When the counter reaches g_timeout_cycles with mem_ready_i still 0, go to DONE.
- In that DONE cycle: timeout_o=1, the owner's ready_o=1, and the owner's data_l_o=32'hDEADBEEF.
- If mem_ready_i=1 in the limit cycle, the transaction completes normally and there is no timeout.

When undefined:
- No counter is built; timeout_o is tied to 0.
- BUSY waits indefinitely for mem_ready_i.

## Test plan
- CPU load to 0x100, mem_ready_i=1 in the first BUSY cycle with data 0x12345678 → mem_load_o=1 in cycle 1 only; cpu_ready_o=1 in cycle 2; cpu_data_l_o=0x12345678; dbg_ready_o stays 0.
- CPU and debug request together after reset → CPU is granted first (grant_o=01). Debug is granted in the IDLE that follows CPU's DONE (grant_o=10). With both still requesting, grants alternate CPU, debug, CPU.
- Debug store to 0x2000 with data 0xA5A5A5A5, select 4'b1111, and mem_ready_i delayed 5 cycles → mem_store_o and the captured fields are held for 6 BUSY cycles; dbg_ready_o=1 exactly once, the cycle after mem_ready_i.
- rst_i pulsed in the third BUSY cycle → mem_store_o=0 at the next edge; grant_o=00; no ready strobe; a new request afterwards is served normally.
- With URV_DM_ARB_TIMEOUT_EN, g_timeout_cycles=8, mem_ready_i held at 0 → BUSY lasts 9 cycles, then timeout_o=1 and cpu_ready_o=1 with cpu_data_l_o=0xDEADBEEF. Without the macro, the arbiter stays in BUSY for 100+ cycles.
- Store then load from the same master, each held until its ready → exactly two memory transactions; no duplicate issue in either DONE cycle.
